// File: rtl/hazard_pipe_ctrl.sv
// RV32I pipeline control: stage-tagged register fields, load-use and
// branch hazard handling, and saturating stall/flush event counters.
module hazard_pipe_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic [4:0]       rd_id,
  input  logic             uses_rs1_id,
  input  logic             uses_rs2_id,
  input  logic             RegWen_id,
  input  logic             MemRead_id,
  input  logic             MemWrite_id,
  input  logic             branch_taken_exe,
  input  logic             ext_stall,
  output logic [4:0]       rs1_exe,
  output logic [4:0]       rs2_exe,
  output logic [4:0]       rd_exe,
  output logic [4:0]       rs2_mem,
  output logic [4:0]       rd_mem,
  output logic [4:0]       rd_wb,
  output logic             RegWen_exe,
  output logic             RegWen_mem,
  output logic             RegWen_wb,
  output logic             MemRead_exe,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             flush_ifid,
  output logic             load_use,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       regwen;
    logic       memread;
  } exe_t;

  typedef struct packed {
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       regwen;
  } mem_t;

  typedef struct packed {
    logic [4:0] rd;
    logic       regwen;
  } wb_t;

  exe_t exe_q;
  exe_t exe_d;
  mem_t mem_q;
  wb_t  wb_q;

  logic rs1_hit;
  logic rs2_hit;
  logic hazard;
  logic is_hold;
  logic is_flush;
  logic is_stall;
  logic bubble;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  assign exe_d = '{
    rs1:     rs1_id,
    rs2:     rs2_id,
    rd:      rd_id,
    regwen:  RegWen_id,
    memread: MemRead_id
  };

  // A store depending on the load only through rs2 is covered by
  // WB-to-MEM forwarding, so it does not stall.
  assign rs1_hit = uses_rs1_id & (rs1_id == exe_q.rd);
  assign rs2_hit = uses_rs2_id & (rs2_id == exe_q.rd)
                 & ~(MemWrite_id & ~rs1_hit);
  assign hazard  = exe_q.memread & (exe_q.rd != 5'd0)
                 & (rs1_hit | rs2_hit);

  assign is_hold  = ext_stall;
  assign is_flush = ~ext_stall & branch_taken_exe;
  assign is_stall = ~ext_stall & ~branch_taken_exe & hazard;

  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    flush_ifid = 1'b0;
    load_use   = 1'b0;
    bubble     = 1'b0;
    unique case (1'b1)
      is_hold: begin
        pc_en   = 1'b0;
        ifid_en = 1'b0;
      end
      is_flush: begin
        flush_ifid = 1'b1;
        bubble     = 1'b1;
      end
      is_stall: begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        load_use = 1'b1;
        bubble   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exe_q <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (!is_hold) begin
      exe_q <= bubble ? '0 : exe_d;
      mem_q <= '{rs2: exe_q.rs2, rd: exe_q.rd, regwen: exe_q.regwen};
      wb_q  <= '{rd: mem_q.rd, regwen: mem_q.regwen};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (is_stall && stall_cnt != CNT_MAX)
        stall_cnt <= stall_cnt + 1'b1;
      if (is_flush && flush_cnt != CNT_MAX)
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign rs1_exe     = exe_q.rs1;
  assign rs2_exe     = exe_q.rs2;
  assign rd_exe      = exe_q.rd;
  assign RegWen_exe  = exe_q.regwen;
  assign MemRead_exe = exe_q.memread;
  assign rs2_mem     = mem_q.rs2;
  assign rd_mem      = mem_q.rd;
  assign RegWen_mem  = mem_q.regwen;
  assign rd_wb       = wb_q.rd;
  assign RegWen_wb   = wb_q.regwen;

endmodule

// File: tb/tb_hazard_pipe_ctrl.sv
// Bench for hazard_pipe_ctrl: directed hazard scenarios plus random
// traffic against a stage-list reference model.
module tb_hazard_pipe_ctrl;

  localparam int CW   = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic [4:0]    rs1_id, rs2_id, rd_id;
  logic          uses_rs1_id, uses_rs2_id;
  logic          RegWen_id, MemRead_id, MemWrite_id;
  logic          branch_taken_exe, ext_stall;
  logic [4:0]    rs1_exe, rs2_exe, rd_exe;
  logic [4:0]    rs2_mem, rd_mem, rd_wb;
  logic          RegWen_exe, RegWen_mem, RegWen_wb;
  logic          MemRead_exe;
  logic          pc_en, ifid_en, flush_ifid, load_use;
  logic [CW-1:0] stall_cnt, flush_cnt;

  hazard_pipe_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id),
    .uses_rs1_id(uses_rs1_id), .uses_rs2_id(uses_rs2_id),
    .RegWen_id(RegWen_id), .MemRead_id(MemRead_id),
    .MemWrite_id(MemWrite_id),
    .branch_taken_exe(branch_taken_exe), .ext_stall(ext_stall),
    .rs1_exe(rs1_exe), .rs2_exe(rs2_exe), .rd_exe(rd_exe),
    .rs2_mem(rs2_mem), .rd_mem(rd_mem), .rd_wb(rd_wb),
    .RegWen_exe(RegWen_exe), .RegWen_mem(RegWen_mem),
    .RegWen_wb(RegWen_wb), .MemRead_exe(MemRead_exe),
    .pc_en(pc_en), .ifid_en(ifid_en), .flush_ifid(flush_ifid),
    .load_use(load_use), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // Model: pipe[0]=EXE, pipe[1]=MEM, pipe[2]=WB
  typedef struct {
    int rs1; int rs2; int rd; int we; int mr;
  } stage_t;

  stage_t pipe[3];
  int     scnt, fcnt;
  int     checks = 0;
  int     errors = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic bit model_hz();
    bit d1, d2;
    d1 = uses_rs1_id && (int'(rs1_id) == pipe[0].rd);
    d2 = uses_rs2_id && (int'(rs2_id) == pipe[0].rd)
         && !(MemWrite_id && !d1);
    return (pipe[0].mr != 0) && (pipe[0].rd != 0) && (d1 || d2);
  endfunction

  task automatic check_all();
    bit hold, fl, st;
    hold = ext_stall;
    fl   = !hold && branch_taken_exe;
    st   = !hold && !branch_taken_exe && model_hz();
    chk("pc_en", pc_en, !(hold || st));
    chk("ifid_en", ifid_en, !(hold || st));
    chk("flush_ifid", flush_ifid, fl);
    chk("load_use", load_use, st);
    chk("rs1_exe", rs1_exe, pipe[0].rs1);
    chk("rs2_exe", rs2_exe, pipe[0].rs2);
    chk("rd_exe", rd_exe, pipe[0].rd);
    chk("we_exe", RegWen_exe, pipe[0].we);
    chk("mr_exe", MemRead_exe, pipe[0].mr);
    chk("rs2_mem", rs2_mem, pipe[1].rs2);
    chk("rd_mem", rd_mem, pipe[1].rd);
    chk("we_mem", RegWen_mem, pipe[1].we);
    chk("rd_wb", rd_wb, pipe[2].rd);
    chk("we_wb", RegWen_wb, pipe[2].we);
    chk("stall_cnt", stall_cnt, scnt);
    chk("flush_cnt", flush_cnt, fcnt);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 3; i++) pipe[i] = '{default: 0};
    scnt = 0;
    fcnt = 0;
  endtask

  // Called at a falling edge with inputs already driven.
  task automatic step();
    bit fl, st;
    #1;
    check_all();
    fl = !ext_stall && branch_taken_exe;
    st = !ext_stall && !branch_taken_exe && model_hz();
    if (!ext_stall) begin
      if (fl && fcnt < CMAX) fcnt++;
      if (st && scnt < CMAX) scnt++;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (fl || st) pipe[0] = '{default: 0};
      else pipe[0] = '{rs1_id, rs2_id, rd_id, RegWen_id, MemRead_id};
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic mid_reset();
    reset_n = 1'b0;
    #1;
    model_clear();
    check_all();
    reset_n = 1'b1;
  endtask

  task automatic id(int r1, int r2, int rd, int u1, int u2,
                    int we, int mr, int mw);
    rs1_id = 5'(r1); rs2_id = 5'(r2); rd_id = 5'(rd);
    uses_rs1_id = 1'(u1); uses_rs2_id = 1'(u2);
    RegWen_id = 1'(we); MemRead_id = 1'(mr); MemWrite_id = 1'(mw);
    branch_taken_exe = 1'b0;
    ext_stall = 1'b0;
  endtask

  logic [4:0] snap_rd_exe, snap_rd_mem, snap_rd_wb;
  int         snap_f;

  initial begin
    model_clear();
    id(0, 0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b0;
    @(negedge clk);
    #1;
    check_all();
    chk("rst_pc_en", pc_en, 1);
    reset_n = 1'b1;
    @(negedge clk);

    // load x5 ; add x6,x5,x1
    id(0, 0, 5, 0, 0, 1, 1, 0); step();
    id(5, 1, 6, 1, 1, 1, 0, 0); step();
    #1;
    chk("bub_rd_exe", rd_exe, 0);
    chk("bub_we_exe", RegWen_exe, 0);
    step();
    #1;
    chk("add_rs1_exe", rs1_exe, 5);
    chk("lu_stall_cnt", stall_cnt, 1);

    // load x5 ; sw x5,0(x2)
    id(0, 0, 5, 0, 0, 1, 1, 0); step();
    id(2, 5, 0, 1, 1, 0, 0, 1);
    #1;
    chk("sw_no_stall", load_use, 0);
    step();
    id(0, 0, 0, 0, 0, 0, 0, 0); step();
    #1;
    chk("sw_rs2_mem", rs2_mem, 5);
    chk("ld_rd_wb", rd_wb, 5);

    // load x0 ; read x0
    id(0, 0, 0, 0, 0, 1, 1, 0); step();
    id(0, 0, 3, 1, 1, 1, 0, 0);
    #1;
    chk("x0_no_hz", load_use, 0);
    step();

    // load-use with simultaneous branch
    mid_reset();
    id(0, 0, 5, 0, 0, 1, 1, 0); step();
    id(5, 0, 6, 1, 0, 1, 0, 0);
    branch_taken_exe = 1'b1;
    #1;
    chk("br_flush", flush_ifid, 1);
    chk("br_pc_en", pc_en, 1);
    chk("br_lu", load_use, 0);
    step();
    branch_taken_exe = 1'b0;
    #1;
    chk("br_bub_rd", rd_exe, 0);
    chk("br_fcnt", flush_cnt, 1);
    chk("br_scnt", stall_cnt, 0);

    // ext_stall freeze with a pending branch
    id(1, 2, 7, 1, 1, 1, 1, 0); step();
    id(3, 4, 8, 1, 1, 1, 0, 0); step();
    id(7, 9, 9, 1, 1, 1, 0, 0);
    #1;
    snap_rd_exe = rd_exe; snap_rd_mem = rd_mem; snap_rd_wb = rd_wb;
    snap_f = fcnt;
    for (int i = 0; i < 3; i++) begin
      ext_stall = 1'b1;
      branch_taken_exe = 1'b1;
      rs1_id = 5'($urandom_range(0, 9));
      step();
    end
    #1;
    chk("frz_rd_exe", rd_exe, snap_rd_exe);
    chk("frz_rd_mem", rd_mem, snap_rd_mem);
    chk("frz_rd_wb", rd_wb, snap_rd_wb);
    ext_stall = 1'b0;
    branch_taken_exe = 1'b1;
    #1;
    chk("frz_flush", flush_ifid, 1);
    step();
    branch_taken_exe = 1'b0;
    step();
    #1;
    chk("frz_fcnt", flush_cnt, snap_f + 1);

    // stall counter saturation, then reset mid-stall
    mid_reset();
    for (int i = 0; i < 10; i++) begin
      id(0, 0, 5, 0, 0, 1, 1, 0); step();
      id(5, 1, 6, 1, 0, 1, 0, 0); step();
      step();
    end
    #1;
    chk("sat_scnt", stall_cnt, CMAX);
    id(0, 0, 5, 0, 0, 1, 1, 0); step();
    id(5, 1, 6, 1, 0, 1, 0, 0);
    #1;
    chk("pre_rst_lu", load_use, 1);
    mid_reset();
    chk("rst_scnt", stall_cnt, 0);
    chk("rst_pc_en2", pc_en, 1);
    step();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      rs1_id = 5'($urandom_range(0, 3));
      rs2_id = 5'($urandom_range(0, 3));
      rd_id  = 5'($urandom_range(0, 3));
      uses_rs1_id = 1'($urandom);
      uses_rs2_id = 1'($urandom);
      RegWen_id   = 1'($urandom);
      MemRead_id  = ($urandom_range(0, 1) == 0);
      MemWrite_id = 1'($urandom);
      branch_taken_exe = ($urandom_range(0, 5) == 0);
      ext_stall        = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 149) == 0) mid_reset();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
